// File: rtl/sobel_gradient_core_pkg.sv
// Shared widths, frame defaults, FSM encoding and arithmetic helpers for the
// Sobel gradient core.
package sobel_gradient_core_pkg;

  localparam int PIX_W      = 8;
  localparam int SUM_W      = 10;
  localparam int DIFF_W     = 11;
  localparam int MAG_W      = 11;
  localparam int ROW_W      = 8;
  localparam int COL_W      = 7;
  localparam int DEF_WIDTH  = 128;
  localparam int DEF_HEIGHT = 128;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic [SUM_W-1:0] weighted_sum(
    input logic [PIX_W-1:0] a,
    input logic [PIX_W-1:0] m,
    input logic [PIX_W-1:0] b
  );
    weighted_sum = {2'b00, a} + {1'b0, m, 1'b0} + {2'b00, b};
  endfunction

  function automatic logic [SUM_W-1:0] abs_diff(
    input logic [SUM_W-1:0] p,
    input logic [SUM_W-1:0] n
  );
    logic [DIFF_W-1:0] d;
    logic [DIFF_W-1:0] neg_d;
    d     = {1'b0, p} - {1'b0, n};
    neg_d = (~d) + 11'd1;
    if (d[DIFF_W-1]) begin
      abs_diff = neg_d[SUM_W-1:0];
    end else begin
      abs_diff = d[SUM_W-1:0];
    end
  endfunction

  function automatic logic [PIX_W-1:0] sat_mag(input logic [MAG_W-1:0] s);
    if (s > 11'd255) begin
      sat_mag = 8'hFF;
    end else begin
      sat_mag = s[PIX_W-1:0];
    end
  endfunction

endpackage

// File: rtl/sobel_grad_axis.sv
// One gradient axis: weighted positive/negative column sums (first stage)
// followed by a registered absolute difference (second stage).
module sobel_grad_axis
  import sobel_gradient_core_pkg::*;
(
  input  logic             clk,
  input  logic             xrst,
  input  logic             i_load_s1,
  input  logic             i_load_s2,
  input  logic [PIX_W-1:0] i_pos_a,
  input  logic [PIX_W-1:0] i_pos_m,
  input  logic [PIX_W-1:0] i_pos_b,
  input  logic [PIX_W-1:0] i_neg_a,
  input  logic [PIX_W-1:0] i_neg_m,
  input  logic [PIX_W-1:0] i_neg_b,
  output logic [SUM_W-1:0] o_abs
);

  logic [SUM_W-1:0] r_pos;
  logic [SUM_W-1:0] r_neg;
  logic [SUM_W-1:0] r_abs;

  // Stage registers only capture when a valid sample is passing through them
  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      r_pos <= 10'd0;
      r_neg <= 10'd0;
      r_abs <= 10'd0;
    end else begin
      if (i_load_s1) begin
        r_pos <= weighted_sum(i_pos_a, i_pos_m, i_pos_b);
        r_neg <= weighted_sum(i_neg_a, i_neg_m, i_neg_b);
      end
      if (i_load_s2) begin
        r_abs <= abs_diff(r_pos, r_neg);
      end
    end
  end

  assign o_abs = r_abs;

endmodule

// File: rtl/sobel_gradient_core.sv
// Sobel |Gx|+|Gy| core: two gradient axes, saturate/threshold stage, tag and
// mode pipeline, and the frame-progress FSM.
module sobel_gradient_core
  import sobel_gradient_core_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) (
  input  logic             clk,
  input  logic             xrst,
  input  logic [PIX_W-1:0] pixel_00,
  input  logic [PIX_W-1:0] pixel_01,
  input  logic [PIX_W-1:0] pixel_02,
  input  logic [PIX_W-1:0] pixel_10,
  input  logic [PIX_W-1:0] pixel_11,
  input  logic [PIX_W-1:0] pixel_12,
  input  logic [PIX_W-1:0] pixel_20,
  input  logic [PIX_W-1:0] pixel_21,
  input  logic [PIX_W-1:0] pixel_22,
  input  logic             win_valid,
  input  logic [ROW_W-1:0] win_row,
  input  logic [COL_W-1:0] win_col,
  input  logic             mode,
  input  logic [PIX_W-1:0] threshold,
  output logic [PIX_W-1:0] edge_out,
  output logic             out_valid,
  output logic [ROW_W-1:0] out_row,
  output logic [COL_W-1:0] out_col,
  output logic             frame_done,
  output logic             busy
);

  logic             w_start;
  logic             w_mode_eff;
  logic [PIX_W-1:0] w_thr_eff;
  logic [SUM_W-1:0] w_abs_x;
  logic [SUM_W-1:0] w_abs_y;
  logic [MAG_W-1:0] w_sum;
  logic [PIX_W-1:0] w_mag;
  logic [PIX_W-1:0] w_edge;
  logic             w_last;
  state_t           r_state;
  state_t           w_next;

  logic             r_lat_mode;
  logic [PIX_W-1:0] r_lat_thr;
  logic             r_v1;
  logic             r_v2;
  logic [ROW_W-1:0] r_row1;
  logic [ROW_W-1:0] r_row2;
  logic [COL_W-1:0] r_col1;
  logic [COL_W-1:0] r_col2;
  logic             r_mode1;
  logic             r_mode2;
  logic [PIX_W-1:0] r_thr1;
  logic [PIX_W-1:0] r_thr2;

  assign w_start = win_valid && (win_row == 8'd0) && (win_col == 7'd0);
  // The (0,0) sample itself already uses the settings presented with it
  assign w_mode_eff = w_start ? mode : r_lat_mode;
  assign w_thr_eff  = w_start ? threshold : r_lat_thr;

  sobel_grad_axis u_gx (
    .clk       (clk),
    .xrst      (xrst),
    .i_load_s1 (win_valid),
    .i_load_s2 (r_v1),
    .i_pos_a   (pixel_02),
    .i_pos_m   (pixel_12),
    .i_pos_b   (pixel_22),
    .i_neg_a   (pixel_00),
    .i_neg_m   (pixel_10),
    .i_neg_b   (pixel_20),
    .o_abs     (w_abs_x)
  );

  sobel_grad_axis u_gy (
    .clk       (clk),
    .xrst      (xrst),
    .i_load_s1 (win_valid),
    .i_load_s2 (r_v1),
    .i_pos_a   (pixel_20),
    .i_pos_m   (pixel_21),
    .i_pos_b   (pixel_22),
    .i_neg_a   (pixel_00),
    .i_neg_m   (pixel_01),
    .i_neg_b   (pixel_02),
    .o_abs     (w_abs_y)
  );

  // Final stage combinational: add, saturate, optional threshold
  always_comb begin
    w_sum  = {1'b0, w_abs_x} + {1'b0, w_abs_y};
    w_mag  = sat_mag(w_sum);
    w_edge = w_mag;
    if (r_mode2) begin
      if (w_mag >= r_thr2) begin
        w_edge = 8'hFF;
      end else begin
        w_edge = 8'h00;
      end
    end else begin
      w_edge = w_mag;
    end
  end

  assign w_last = (r_row2 == ROW_W'(HEIGHT - 1)) && (r_col2 == COL_W'(WIDTH - 1));

  // Frame settings latch and valid/tag/settings pipeline
  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      r_lat_mode <= 1'b0;
      r_lat_thr  <= 8'd0;
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_row1     <= 8'd0;
      r_row2     <= 8'd0;
      r_col1     <= 7'd0;
      r_col2     <= 7'd0;
      r_mode1    <= 1'b0;
      r_mode2    <= 1'b0;
      r_thr1     <= 8'd0;
      r_thr2     <= 8'd0;
    end else begin
      r_v1 <= win_valid;
      r_v2 <= r_v1;
      if (w_start) begin
        r_lat_mode <= mode;
        r_lat_thr  <= threshold;
      end
      if (win_valid) begin
        r_row1  <= win_row;
        r_col1  <= win_col;
        r_mode1 <= w_mode_eff;
        r_thr1  <= w_thr_eff;
      end
      if (r_v1) begin
        r_row2  <= r_row1;
        r_col2  <= r_col1;
        r_mode2 <= r_mode1;
        r_thr2  <= r_thr1;
      end
    end
  end

  // Output registers hold their value through bubbles
  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      edge_out   <= 8'd0;
      out_row    <= 8'd0;
      out_col    <= 7'd0;
    end else begin
      out_valid  <= r_v2;
      frame_done <= r_v2 && w_last;
      if (r_v2) begin
        edge_out <= w_edge;
        out_row  <= r_row2;
        out_col  <= r_col2;
      end
    end
  end

  // Frame FSM state register
  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Frame FSM next state; a (0,0) entering alongside frame_done keeps RUN
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_next = ST_RUN;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (frame_done && !w_start) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_RUN;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign busy = (r_state == ST_RUN);

endmodule

// File: tb/tb_sobel_gradient_core.sv
// Directed self-checking bench for sobel_gradient_core: hand-computed windows,
// full-frame rasters against a kernel reference, reset abort and FSM corners.
module tb_sobel_gradient_core;

  logic       clk = 1'b0;
  logic       xrst;
  logic [7:0] win [9];
  logic       win_valid;
  logic [7:0] win_row;
  logic [6:0] win_col;
  logic       mode;
  logic [7:0] threshold;
  logic [7:0] edge_out;
  logic       out_valid;
  logic [7:0] out_row;
  logic [6:0] out_col;
  logic       frame_done;
  logic       busy;

  typedef struct packed {
    logic [7:0] e;
    logic [7:0] r;
    logic [6:0] c;
    logic       fd;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   fd_seen = 0;
  int   n_out = 0;
  int   fd0 = 0;
  bit   busy_drop_chk = 1'b0;

  always #5 clk = ~clk;

  sobel_gradient_core dut (
    .clk        (clk),
    .xrst       (xrst),
    .pixel_00   (win[0]),
    .pixel_01   (win[1]),
    .pixel_02   (win[2]),
    .pixel_10   (win[3]),
    .pixel_11   (win[4]),
    .pixel_12   (win[5]),
    .pixel_20   (win[6]),
    .pixel_21   (win[7]),
    .pixel_22   (win[8]),
    .win_valid  (win_valid),
    .win_row    (win_row),
    .win_col    (win_col),
    .mode       (mode),
    .threshold  (threshold),
    .edge_out   (edge_out),
    .out_valid  (out_valid),
    .out_row    (out_row),
    .out_col    (out_col),
    .frame_done (frame_done),
    .busy       (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_cols(input logic [7:0] l, input logic [7:0] m, input logic [7:0] r);
    for (int i = 0; i < 3; i++) begin
      win[i*3+0] = l;
      win[i*3+1] = m;
      win[i*3+2] = r;
    end
  endtask

  task automatic set_rows(input logic [7:0] t, input logic [7:0] m, input logic [7:0] b);
    for (int i = 0; i < 3; i++) begin
      win[i]   = t;
      win[3+i] = m;
      win[6+i] = b;
    end
  endtask

  // Independent reference: explicit signed 3x3 kernels over the window
  function automatic logic [7:0] sobel_ref(input logic md, input logic [7:0] thr);
    int kx[9];
    int ky[9];
    int gx;
    int gy;
    int s;
    kx = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    ky = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
    gx = 0;
    gy = 0;
    for (int i = 0; i < 9; i++) begin
      gx += kx[i] * int'(win[i]);
      gy += ky[i] * int'(win[i]);
    end
    s = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
    if (s > 255) s = 255;
    if (md) return (s >= int'(thr)) ? 8'd255 : 8'd0;
    return 8'(s);
  endfunction

  task automatic send_chk(input logic [7:0] r, input logic [6:0] c,
                          input logic [7:0] exp_e, input string name);
    win_row = r;
    win_col = c;
    win_valid = 1'b1;
    tick();
    win_valid = 1'b0;
    chk({name, "_lat1"}, out_valid, 0);
    tick();
    chk({name, "_lat2"}, out_valid, 0);
    tick();
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_edge"}, edge_out, exp_e);
    chk({name, "_row"}, out_row, r);
    chk({name, "_col"}, out_col, c);
  endtask

  task automatic check_out();
    exp_t e;
    if (busy_drop_chk) begin
      chk("busy_drop", busy, 0);
      busy_drop_chk = 1'b0;
    end
    if (out_valid) begin
      n_out++;
      if (q.size() == 0) begin
        chk("unexpected_valid", out_valid, 0);
      end else begin
        e = q.pop_front();
        chk("raster_out", {edge_out, out_row, out_col, frame_done}, e);
      end
      if (frame_done) begin
        fd_seen++;
        if (fd_seen == 1) begin
          chk("busy_at_done", busy, 1);
          busy_drop_chk = 1'b1;
        end
      end
    end
  endtask

  task automatic drive_frame(input logic md, input logic [7:0] thr0, input logic [7:0] thr1,
                             input int chg_r, input int chg_c,
                             input int last_r, input int last_c, input bit bub);
    logic       lat_m;
    logic [7:0] lat_t;
    exp_t       e;
    lat_m = 1'b0;
    lat_t = 8'd0;
    for (int r = 0; r < 128; r++) begin
      for (int c = 0; c < 128; c++) begin
        for (int k = 0; k < 9; k++) win[k] = 8'($urandom_range(0, 47));
        win_row   = 8'(r);
        win_col   = 7'(c);
        mode      = md;
        threshold = ((r > chg_r) || (r == chg_r && c >= chg_c)) ? thr1 : thr0;
        if (r == 0 && c == 0) begin
          lat_m = mode;
          lat_t = threshold;
        end
        e.e  = sobel_ref(lat_m, lat_t);
        e.r  = 8'(r);
        e.c  = 7'(c);
        e.fd = (r == 127 && c == 127);
        q.push_back(e);
        win_valid = 1'b1;
        tick();
        check_out();
        win_valid = 1'b0;
        if (r == last_r && c == last_c) return;
        if (bub && !(r == 127 && c == 127) && $urandom_range(0, 7) == 0) begin
          repeat ($urandom_range(1, 3)) begin
            tick();
            check_out();
          end
        end
      end
    end
  endtask

  task automatic drain();
    repeat (6) begin
      tick();
      check_out();
    end
  endtask

  initial begin
    xrst = 1'b1;
    win_valid = 1'b0;
    win_row = 8'd0;
    win_col = 7'd0;
    mode = 1'b0;
    threshold = 8'd0;
    set_cols(8'd0, 8'd0, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_edge", edge_out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_row", out_row, 0);
    chk("rst_col", out_col, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_busy", busy, 0);
    xrst = 1'b0;
    tick();

    // Flat window, exact latency
    set_cols(8'd100, 8'd100, 8'd100);
    send_chk(8'd5, 7'd3, 8'd0, "flat");

    // Horizontal ramp saturates; mode input ignored outside (0,0)
    mode = 1'b1;
    threshold = 8'd0;
    set_cols(8'd0, 8'd128, 8'd255);
    send_chk(8'd6, 7'd10, 8'd255, "sat");
    tick();
    chk("hold_valid", out_valid, 0);
    chk("hold_edge", edge_out, 255);

    // Negative Gy only: |-160| = 160
    set_rows(8'd50, 8'd20, 8'd10);
    send_chk(8'd7, 7'd1, 8'd160, "neg_gy");

    // Gx=-140, Gy=+60 -> 200
    win = '{8'd40, 8'd0, 8'd0, 8'd40, 8'd0, 8'd0, 8'd40, 8'd20, 8'd20};
    send_chk(8'd7, 7'd2, 8'd200, "mixed");

    // Binary mode, S=40 against threshold boundary
    set_cols(8'd10, 8'd15, 8'd20);
    mode = 1'b1;
    threshold = 8'd40;
    send_chk(8'd0, 7'd0, 8'd255, "thr_eq");
    threshold = 8'd41;
    send_chk(8'd0, 7'd0, 8'd0, "thr_above");
    threshold = 8'd0;
    send_chk(8'd3, 7'd4, 8'd0, "thr_midframe");
    chk("busy_run", busy, 1);

    // Two back-to-back frames with bubbles; threshold changes at (60,5)
    q.delete();
    n_out = 0;
    drive_frame(1'b1, 8'd100, 8'd30, 60, 5, 200, 0, 1'b1);
    drive_frame(1'b1, 8'd30, 8'd30, 200, 0, 200, 0, 1'b1);
    drain();
    chk("out_count_2frames", n_out, 32768);
    chk("fd_count_2frames", fd_seen, 2);

    // Reset mid-frame with samples in flight
    drive_frame(1'b0, 8'd0, 8'd0, 200, 0, 40, 17, 1'b0);
    xrst = 1'b1;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_edge", edge_out, 0);
    chk("abort_row", out_row, 0);
    chk("abort_col", out_col, 0);
    chk("abort_fd", frame_done, 0);
    chk("abort_busy", busy, 0);
    q.delete();
    @(negedge clk);
    xrst = 1'b0;
    repeat (6) begin
      tick();
      chk("abort_no_valid", out_valid, 0);
      chk("abort_no_fd", frame_done, 0);
    end

    // Fresh frame after abort, magnitude mode, no bubbles
    n_out = 0;
    fd0 = fd_seen;
    drive_frame(1'b0, 8'd0, 8'd0, 200, 0, 200, 0, 1'b0);
    drain();
    chk("fresh_out_count", n_out, 16384);
    chk("fresh_fd_count", fd_seen - fd0, 1);
    chk("idle_after_frame", busy, 0);

    // (0,0) entering on the frame_done edge keeps the FSM in RUN
    set_cols(8'd1, 8'd1, 8'd1);
    mode = 1'b0;
    win_row = 8'd0;
    win_col = 7'd0;
    win_valid = 1'b1;
    tick();
    win_valid = 1'b0;
    chk("busy_start", busy, 1);
    win_row = 8'd127;
    win_col = 7'd127;
    win_valid = 1'b1;
    tick();
    win_valid = 1'b0;
    tick();
    tick();
    chk("fd_directed", frame_done, 1);
    chk("busy_on_done", busy, 1);
    win_row = 8'd0;
    win_col = 7'd0;
    win_valid = 1'b1;
    tick();
    win_valid = 1'b0;
    chk("stay_run", busy, 1);
    chk("fd_one_cycle", frame_done, 0);
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
